// File: rtl/ram_data_arbiter.sv
// ram_data_arbiter: round-robin arbiter sharing a single-port data RAM
// between NUM_CORES cores. Each granted request gets one ACCESS cycle on
// the RAM bus followed by a one-cycle ack pulse (DONE).
module ram_data_arbiter #(
   parameter int NUM_CORES = 4,
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_CORES-1:0]        core_req,
   input  logic [NUM_CORES-1:0]        core_we,
   input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
   input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
   output logic [NUM_CORES-1:0]        core_ack,
   output logic [DATA_W-1:0]           core_rdata,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   output logic                        mem_wr,
   output logic                        mem_rd,
   input  logic [DATA_W-1:0]           mem_rdata,
   output logic                        busy
);

   localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   last_grant;
   logic [IDX_W-1:0]   winner;
   logic [IDX_W-1:0]   pick;
   logic               pick_valid;
   logic [NUM_CORES-1:0] winner_onehot;

   logic [ADDR_W-1:0]  addr_arr  [NUM_CORES];
   logic [DATA_W-1:0]  wdata_arr [NUM_CORES];

   // Unpack the flattened per-core buses and decode the winner into a one-hot ack vector
   for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
      assign addr_arr[gi]      = core_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi]     = core_wdata[gi*DATA_W +: DATA_W];
      assign winner_onehot[gi] = (winner == IDX_W'(gi));
   end

   assign busy = (state != IDLE);

   // Round-robin pick: first requester found scanning upward from last_grant+1.
   // The loop runs from the farthest candidate to the nearest so the nearest overwrites.
   always_comb begin
      int cand;
      cand       = 0;
      pick       = last_grant;
      pick_valid = 1'b0;
      for (int k = NUM_CORES; k >= 1; k--) begin
         cand = (int'(last_grant) + k) % NUM_CORES;
         if (core_req[cand]) begin
            pick       = IDX_W'(cand);
            pick_valid = 1'b1;
         end
      end
   end

   // Arbitration FSM; all RAM-side and core-side outputs are registered here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= IDX_W'(NUM_CORES - 1);
         winner     <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wr     <= 1'b0;
         mem_rd     <= 1'b0;
         core_ack   <= '0;
         core_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               core_ack <= '0;
               if (pick_valid) begin
                  // Latch the winner's transaction; mem_* stay frozen through ACCESS
                  // so other cores' bus activity cannot disturb the RAM cycle.
                  winner    <= pick;
                  mem_addr  <= addr_arr[pick];
                  mem_wdata <= wdata_arr[pick];
                  mem_wr    <= core_we[pick];
                  mem_rd    <= ~core_we[pick];
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               // Only a read updates core_rdata; after a write the last read value persists.
               if (mem_rd) begin
                  core_rdata <= mem_rdata;
               end
               mem_wr     <= 1'b0;
               mem_rd     <= 1'b0;
               last_grant <= winner;
               core_ack   <= winner_onehot;
               state      <= DONE;
            end
            DONE: begin
               core_ack <= '0;
               state    <= IDLE;
            end
            default: begin
               core_ack <= '0;
               mem_wr   <= 1'b0;
               mem_rd   <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_data_arbiter.sv
// Bench for ram_data_arbiter: directed scenarios plus randomized traffic,
// checked by a scoreboard monitor against a simple memory/arbitration model.
module tb_ram_data_arbiter;

   localparam int NC = 4;
   localparam int AW = 16;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst_n;
   logic [NC-1:0]    core_req;
   logic [NC-1:0]    core_we;
   logic [NC*AW-1:0] core_addr;
   logic [NC*DW-1:0] core_wdata;
   logic [NC-1:0]    core_ack;
   logic [DW-1:0]    core_rdata;
   logic [AW-1:0]    mem_addr;
   logic [DW-1:0]    mem_wdata;
   logic             mem_wr;
   logic             mem_rd;
   logic [DW-1:0]    mem_rdata;
   logic             busy;

   ram_data_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_ack(core_ack), .core_rdata(core_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural RAM: synchronous write, combinational read, garbage when not read-strobed
   logic [DW-1:0] ram [0:255] = '{default: '0};
   always @(posedge clk) if (mem_wr) ram[mem_addr[7:0]] <= mem_wdata;
   assign mem_rdata = mem_rd ? ram[mem_addr[7:0]] : 16'hDEAD;

   // Each core's request is outstanding while it has issued more than were acked or dropped
   int issued [NC] = '{default: 0};
   int acked  [NC] = '{default: 0};
   int dropped[NC] = '{default: 0};
   always_comb begin
      core_req = '0;
      for (int i = 0; i < NC; i++) core_req[i] = (issued[i] != acked[i] + dropped[i]);
   end

   typedef struct {
      bit          we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      int          cyc;
   } txn_t;

   txn_t exp_q[NC][$];
   int   order_q[$];
   logic [15:0] model_mem [0:255] = '{default: '0};
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Issue one request from core c; tracked requests push their expected response
   task automatic issue(input int c, input bit we, input logic [15:0] a, input logic [15:0] d,
                        input int ecyc, input bit track);
      txn_t t;
      core_we[c] = we;
      core_addr[c*AW +: AW]  = a;
      core_wdata[c*DW +: DW] = d;
      if (track) begin
         t.we    = we;
         t.addr  = a;
         t.wdata = d;
         t.rdata = we ? 16'h0 : model_mem[a[7:0]];
         t.cyc   = ecyc;
         exp_q[c].push_back(t);
         if (we) model_mem[a[7:0]] = d;
      end
      issued[c]++;
   endtask

   // Wait (bounded) until every expected response has been seen
   task automatic drain(input string name);
      bit done;
      done = 1'b0;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge clk);
         done = 1'b1;
         for (int i = 0; i < NC; i++) if (exp_q[i].size() != 0) done = 1'b0;
         if (order_q.size() != 0) done = 1'b0;
      end
      chk({"drain_", name}, 32'(done), 32'd1);
      if (!done) begin
         for (int i = 0; i < NC; i++) begin
            if (core_req[i]) dropped[i]++;
            exp_q[i].delete();
         end
         order_q.delete();
      end
      @(negedge clk);
   endtask

   // Monitor: records each RAM access, then scores it when the ack pulse appears
   initial begin
      logic [15:0] acc_addr, acc_wdata, last_rd;
      bit          acc_wr;
      int          acc_cyc, c;
      txn_t        e;
      acc_cyc = -10; last_rd = '0; acc_addr = '0; acc_wdata = '0; acc_wr = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            acc_cyc = -10;
            last_rd = '0;
         end else begin
            if (mem_wr || mem_rd) begin
               chk("strobe_exclusive", 32'(mem_wr & mem_rd), 32'd0);
               acc_addr = mem_addr; acc_wdata = mem_wdata; acc_wr = mem_wr; acc_cyc = cyc;
            end
            if (core_ack != '0) begin
               chk("ack_onehot", 32'($countones(core_ack)), 32'd1);
               c = 0;
               for (int i = NC-1; i >= 0; i--) if (core_ack[i]) c = i;
               if (exp_q[c].size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL unexpected_ack: core %0d acked at cycle %0d, required no ack", c, cyc);
               end else begin
                  e = exp_q[c].pop_front();
                  $display("txn core%0d %s addr=%h wdata=%h rdata=%h cycle=%0d",
                           c, e.we ? "WR" : "RD", e.addr, e.wdata, core_rdata, cyc);
                  if (e.cyc >= 0) chk("ack_latency", 32'(cyc), 32'(e.cyc));
                  if (order_q.size() > 0) chk("grant_order", 32'(c), 32'(order_q.pop_front()));
                  chk("access_cycle", 32'(acc_cyc), 32'(cyc - 1));
                  chk("access_addr", 32'(acc_addr), 32'(e.addr));
                  chk("access_we", 32'(acc_wr), 32'(e.we));
                  if (e.we) chk("access_wdata", 32'(acc_wdata), 32'(e.wdata));
                  chk("busy_in_done", 32'(busy), 32'd1);
                  if (e.we) begin
                     chk("rdata_kept", 32'(core_rdata), 32'(last_rd));
                  end else begin
                     chk("read_data", 32'(core_rdata), 32'(e.rdata));
                     last_rd = e.rdata;
                  end
                  acked[c]++;
               end
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Stimulus
   initial begin
      int n, c;
      rst_n = 1'b0; core_we = '0; core_addr = '0; core_wdata = '0;
      repeat (2) @(negedge clk);

      // Reset with all four cores requesting writes; after release grants go 0,1,2,3
      for (int i = 0; i < NC; i++) begin
         issue(i, 1'b1, 16'(16'h0010 + i), 16'(16'hA000 + i), cyc + 4 + 3*i, 1'b1);
         order_q.push_back(i);
      end
      @(negedge clk);
      chk("rst_core_ack", 32'(core_ack), 32'd0);
      chk("rst_mem_wr", 32'(mem_wr), 32'd0);
      chk("rst_mem_rd", 32'(mem_rd), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_core_rdata", 32'(core_rdata), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drain("reset_contention");

      // Single write then read from core 2
      issue(2, 1'b1, 16'h0040, 16'hBEEF, cyc + 2, 1'b1);
      drain("core2_write");
      issue(2, 1'b0, 16'h0040, 16'h0000, cyc + 2, 1'b1);
      drain("core2_read");

      // Read back contention writes; last grant was core 2 so order is 3,0,1,2
      n = cyc;
      for (int k = 0; k < NC; k++) begin
         c = (3 + k) % NC;
         issue(c, 1'b0, 16'(16'h0010 + c), 16'h0000, n + 2 + 3*k, 1'b1);
         order_q.push_back(c);
      end
      drain("readback");

      // Core 1 alone, then cores 0 and 3 together: core 3 wins first
      issue(1, 1'b1, 16'h0070, 16'h7777, cyc + 2, 1'b1);
      order_q.push_back(1);
      drain("core1_alone");
      n = cyc;
      issue(0, 1'b1, 16'h0030, 16'h3030, n + 5, 1'b1);
      issue(3, 1'b1, 16'h00F0, 16'hF0F0, n + 2, 1'b1);
      order_q.push_back(3);
      order_q.push_back(0);
      drain("rr_pointer");

      // Non-winning core changes its bus during ACCESS; RAM bus must not move
      issue(0, 1'b1, 16'h0020, 16'h5A5A, cyc + 2, 1'b1);
      @(posedge clk);
      #1;
      core_addr[3*AW +: AW]  = 16'hFFFF;
      core_wdata[3*DW +: DW] = 16'h1111;
      @(negedge clk);
      chk("hold_mem_addr", 32'(mem_addr), 32'h0020);
      chk("hold_mem_wdata", 32'(mem_wdata), 32'h5A5A);
      drain("hold");

      // Reset in the middle of a write ACCESS: strobe drops at once, no ack, no commit
      issue(1, 1'b1, 16'h0050, 16'h1234, 0, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_mem_wr", 32'(mem_wr), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_ack", 32'(core_ack), 32'd0);
      dropped[1]++;
      repeat (2) @(negedge clk);
      chk("midrst_ack_hold", 32'(core_ack), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      issue(0, 1'b0, 16'h0050, 16'h0000, cyc + 2, 1'b1);
      drain("after_midreset");

      // Random traffic, each core confined to its own address quarter
      repeat (400) begin
         @(negedge clk);
         for (int i = 0; i < NC; i++) begin
            if (!core_req[i] && $urandom_range(2) == 0)
               issue(i, 1'($urandom_range(1)), {8'h00, 2'(i), 6'($urandom)}, 16'($urandom), -1, 1'b1);
         end
      end
      drain("random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ram_data_arbiter.md
Name: ram_data_arbiter

Overview:
- Round-robin arbiter that shares the single-port data RAM between NUM_CORES processor cores.
- Each core issues one read or write through a req/ack handshake. The arbiter serialises the requests, drives the RAM address, data and control lines for exactly one ACCESS cycle, and returns read data with a one-cycle ack pulse.
- Sits between the core load/store units and the data RAM in the multicore top level.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8).
- ADDR_W, 16, RAM address width.
- DATA_W, 16, RAM data width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- core_req  input  NUM_CORES  per-core request, bit i = core i.
- core_we  input  NUM_CORES  per-core write enable: 1 = write, 0 = read. Meaningful only while core_req[i] is high.
- core_addr  input  NUM_CORES*ADDR_W  flattened addresses; core i occupies [i*ADDR_W +: ADDR_W].
- core_wdata  input  NUM_CORES*DATA_W  flattened write data, same packing as core_addr.
- core_ack  output  NUM_CORES  one-hot, one-cycle completion pulse.
- core_rdata  output  DATA_W  read data for the core currently acked. Shared by all cores.
- mem_addr  output  ADDR_W  to RAM address bus.
- mem_wdata  output  DATA_W  to RAM data input.
- mem_wr  output  1  to RAM write strobe.
- mem_rd  output  1  to RAM read strobe.
- mem_rdata  input  DATA_W  from RAM data output (high-Z while mem_rd is low).
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, rst_n=0), applied immediately:
  - FSM = IDLE; core_ack = 0; core_rdata = 0.
  - mem_addr = 0; mem_wdata = 0; mem_wr = 0; mem_rd = 0; busy = 0.
  - last_grant = NUM_CORES-1, so core 0 has top priority after reset.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - On a rising edge with any core_req bit set, pick the winner by scanning from last_grant+1 upward, mod NUM_CORES.
  - Register the winner's index, addr, wdata and we. Move to ACCESS.
  - With no request, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_addr and mem_wdata are the registered values.
  - mem_wr = we; mem_rd = ~we.
  - All mem_* outputs are held stable for the whole cycle.
  - On the closing rising edge:
    - A write commits in the RAM.
    - A read captures mem_rdata into core_rdata.
  - Then mem_wr = mem_rd = 0, last_grant = winner, and the FSM moves to DONE.
- DONE (1 cycle):
  - core_ack[winner] = 1; all other ack bits 0.
  - core_rdata stays valid from DONE until the next read completes. It is not cleared after a write.
  - Next state is IDLE.
- Handshake rules:
  - A core holds req, we, addr and wdata constant from assertion until it samples ack=1.
  - The core deasserts req on that same edge; otherwise it is treated as a new request.
  - A request cannot be withdrawn before ack. Deassertion before ack is a protocol violation; the latched transaction still completes.
- Latency: req sampled at edge k gives ACCESS in cycle k+1 and ack high in cycle k+2. Minimum 3 cycles per transaction; peak throughput is 1 access per 3 cycles.
- Fairness:
  - With all cores requesting continuously, grants rotate 0,1,2,…,NUM_CORES-1,0.
  - Worst-case wait is NUM_CORES transactions.
- Simultaneous events:
  - Requests arriving during ACCESS or DONE wait for IDLE; they are not queued ahead of others.
  - Input changes from non-winning cores during ACCESS never affect the mem_* outputs.
- Reset mid-operation:
  - Any in-flight access is abandoned: mem_wr drops immediately and no ack is issued.
  - A write whose commit edge coincides with reset assertion is not guaranteed.
- mem_rd is low outside ACCESS, so the RAM output floats; core_rdata never samples while mem_rd=0.

Test Plan:
- Reset: hold rst_n=0 with core_req=4'b1111 → all outputs 0, busy=0; release → first grant to core 0.
- Single write then read, core 2:
  - Write addr 0x0040, data 0xBEEF → mem_wr=1 for exactly 1 cycle, ack[2] two cycles after req.
  - Read 0x0040 → core_rdata=0xBEEF while ack[2]=1.
- Contention: all 4 cores request writes to 0x0010+i with data 0xA000+i in the same cycle → acks in order 0,1,2,3, spaced 3 cycles apart. Read-back gives 0xA000..0xA003.
- Round-robin pointer:
  - Core 1 is served alone.
  - Then cores 0 and 3 request together → core 3 is granted before core 0.
- Hold stability: change core_addr of a non-winning core during ACCESS → mem_addr unchanged; the winner's transaction completes correctly.
- Reset mid-ACCESS: assert rst_n=0 during a write cycle → mem_wr=0 immediately, no ack. After release a new request from core 0 succeeds with normal 3-cycle latency.
